vram_arbiter: RTL and testbench

Shares the single-port synchronous video RAM between the display fetch pipeline and the CPU port of the VDP. Display fetches are pipelined at one access per cycle and normally win. The CPU port uses a held request / single-cycle acknowledge handshake and is protected from starvation by a bounded-wait counter. The block sits between the fetch logic driven by the sync generator's xPos/yPos/isActive and the Ram instance.

---
 rtl/vdp_pkg.sv | 21 ++
 rtl/vram_cpu_port.sv | 56 +++++
 rtl/vram_arbiter.sv | 115 +++++++++++
 tb/tb_vram_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// Shared VDP definitions: default VRAM geometry, CPU port FSM states and
// the owner tags carried by the VRAM read-return pipeline.
package vdp_pkg;

  localparam int unsigned DEF_ADDR_W = 14;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    C_IDLE,
    C_ISSUE,
    C_WAIT,
    C_ACK
  } cpuState_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_CPU
  } owner_t;

endpackage

// File: rtl/vram_cpu_port.sv
// CPU side of the VRAM arbiter: request/acknowledge FSM, captured access
// direction and the registered read data returned with cpuAck.
module vram_cpu_port
  import vdp_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic              accept,
  input  logic              rdCapture,
  input  logic [DATA_W-1:0] ramRData,
  output logic              cpuCand,
  output logic              cpuAck,
  output logic [DATA_W-1:0] cpuRData
);

  cpuState_t state;
  cpuState_t stateNext;
  logic      weCap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= C_IDLE;
      weCap    <= 1'b0;
      cpuRData <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        weCap <= cpuWe;
      end
      if (rdCapture) begin
        cpuRData <= ramRData;
      end
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      C_IDLE:  if (accept) stateNext = C_ISSUE;
      C_ISSUE: stateNext = weCap ? C_ACK : C_WAIT;
      C_WAIT:  stateNext = C_ACK;
      C_ACK:   stateNext = C_IDLE;
      default: stateNext = C_IDLE;
    endcase
  end

  // Request lines are only looked at while idle, so a held cpuReq is ignored
  // until the cycle after cpuAck.
  assign cpuCand = (state == C_IDLE) && cpuReq;
  assign cpuAck  = (state == C_ACK);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetches win by default, the CPU is forced
// through after STARVE_MAX lost arbitrations; reads return via a tag pipeline.
module vram_arbiter
  import vdp_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dispReq,
  input  logic [ADDR_W-1:0] dispAddr,
  output logic              dispGnt,
  output logic              dispValid,
  output logic [DATA_W-1:0] dispData,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWData,
  output logic              cpuAck,
  output logic [DATA_W-1:0] cpuRData,
  output logic [ADDR_W-1:0] ramAddr,
  output logic              ramWe,
  output logic [DATA_W-1:0] ramWData,
  input  logic [DATA_W-1:0] ramRData
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic       cpuCand;
  logic       cpuWin;
  logic       dispWin;
  logic       rdCapture;
  logic [3:0] starveCnt;
  owner_t     tagIssue;
  owner_t     tagData;
  owner_t     tagNext;

  vram_cpu_port #(
    .DATA_W(DATA_W)
  ) cpuPort (
    .clk      (clk),
    .reset    (reset),
    .cpuReq   (cpuReq),
    .cpuWe    (cpuWe),
    .accept   (cpuWin),
    .rdCapture(rdCapture),
    .ramRData (ramRData),
    .cpuCand  (cpuCand),
    .cpuAck   (cpuAck),
    .cpuRData (cpuRData)
  );

  always_comb begin
    cpuWin  = cpuCand && (!dispReq || (starveCnt == STARVE_LIM));
    dispWin = dispReq && !cpuWin;
    tagNext = OWN_NONE;
    if (cpuWin) begin
      tagNext = cpuWe ? OWN_NONE : OWN_CPU;
    end else if (dispWin) begin
      tagNext = OWN_DISP;
    end
  end

  assign rdCapture = (tagData == OWN_CPU);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starveCnt <= '0;
    end else if (!cpuCand || cpuWin) begin
      starveCnt <= '0;
    end else if (starveCnt < STARVE_LIM) begin
      starveCnt <= starveCnt + 4'd1;
    end
  end

  // ramAddr/ramWData only move on an accepted access; idle cycles keep them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dispGnt  <= 1'b0;
      ramWe    <= 1'b0;
      ramAddr  <= '0;
      ramWData <= '0;
    end else begin
      dispGnt <= dispWin;
      ramWe   <= cpuWin && cpuWe;
      if (cpuWin) begin
        ramAddr  <= cpuAddr;
        ramWData <= cpuWData;
      end else if (dispWin) begin
        ramAddr <= dispAddr;
      end
    end
  end

  // tagIssue marks the cycle ramAddr is presented, tagData the cycle
  // ramRData is valid for that access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tagIssue  <= OWN_NONE;
      tagData   <= OWN_NONE;
      dispValid <= 1'b0;
      dispData  <= '0;
    end else begin
      tagIssue  <= tagNext;
      tagData   <= tagIssue;
      dispValid <= (tagData == OWN_DISP);
      if (tagData == OWN_DISP) begin
        dispData <= ramRData;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a synchronous single-port RAM model;
// inputs change 1 time unit after each rising edge, outputs checked there too.
module tb_vram_arbiter;
  import vdp_pkg::*;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              dispReq = 1'b0;
  logic [ADDR_W-1:0] dispAddr = '0;
  logic              dispGnt;
  logic              dispValid;
  logic [DATA_W-1:0] dispData;
  logic              cpuReq = 1'b0;
  logic              cpuWe = 1'b0;
  logic [ADDR_W-1:0] cpuAddr = '0;
  logic [DATA_W-1:0] cpuWData = '0;
  logic              cpuAck;
  logic [DATA_W-1:0] cpuRData;
  logic [ADDR_W-1:0] ramAddr;
  logic              ramWe;
  logic [DATA_W-1:0] ramWData;
  logic [DATA_W-1:0] ramRData = '0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  vram_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .dispReq  (dispReq),
    .dispAddr (dispAddr),
    .dispGnt  (dispGnt),
    .dispValid(dispValid),
    .dispData (dispData),
    .cpuReq   (cpuReq),
    .cpuWe    (cpuWe),
    .cpuAddr  (cpuAddr),
    .cpuWData (cpuWData),
    .cpuAck   (cpuAck),
    .cpuRData (cpuRData),
    .ramAddr  (ramAddr),
    .ramWe    (ramWe),
    .ramWData (ramWData),
    .ramRData (ramRData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ramWe) mem[ramAddr] <= ramWData;
    ramRData <= mem[ramAddr];
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int unsigned i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem[14'h0123] = 8'h5A;
    mem[14'h0200] = 8'h77;
    for (int unsigned i = 0; i < 8; i++) mem[14'h0100 + i] = 8'(i);

    // reset state
    tick();
    tick();
    checkVal("rst_dispGnt", dispGnt, 0);
    checkVal("rst_dispValid", dispValid, 0);
    checkVal("rst_dispData", dispData, 0);
    checkVal("rst_cpuAck", cpuAck, 0);
    checkVal("rst_cpuRData", cpuRData, 0);
    checkVal("rst_ramAddr", ramAddr, 0);
    checkVal("rst_ramWe", ramWe, 0);
    checkVal("rst_ramWData", ramWData, 0);
    reset = 1'b1;
    tick();

    // single display read
    dispReq = 1'b1;
    dispAddr = 14'h0123;
    tick();
    checkVal("d1_gnt", dispGnt, 1);
    checkVal("d1_ramAddr", ramAddr, 14'h0123);
    checkVal("d1_ramWe", ramWe, 0);
    dispReq = 1'b0;
    tick();
    checkVal("d2_gnt", dispGnt, 0);
    checkVal("d2_valid", dispValid, 0);
    tick();
    checkVal("d3_valid", dispValid, 1);
    checkVal("d3_data", dispData, 8'h5A);
    tick();
    checkVal("d4_valid", dispValid, 0);

    // eight back-to-back fetches, next address presented in the grant cycle
    dispReq = 1'b1;
    dispAddr = 14'h0100;
    for (int c = 1; c <= 11; c++) begin
      tick();
      checkVal("b2b_gnt", dispGnt, (c >= 1 && c <= 8) ? 1 : 0);
      if (c <= 8) checkVal("b2b_ramAddr", ramAddr, 32'h100 + c - 1);
      checkVal("b2b_valid", dispValid, (c >= 3 && c <= 10) ? 1 : 0);
      if (c >= 3 && c <= 10) checkVal("b2b_data", dispData, c - 3);
      if (c < 8) begin
        dispAddr = 14'(14'h0100 + c);
      end else begin
        dispReq = 1'b0;
      end
    end

    // CPU write to the top address
    cpuReq = 1'b1;
    cpuWe = 1'b1;
    cpuAddr = 14'h3FFF;
    cpuWData = 8'hA5;
    tick();
    checkVal("w1_ramWe", ramWe, 1);
    checkVal("w1_ramAddr", ramAddr, 14'h3FFF);
    checkVal("w1_ramWData", ramWData, 8'hA5);
    checkVal("w1_ack", cpuAck, 0);
    tick();
    checkVal("w2_ack", cpuAck, 1);
    checkVal("w2_ramWe", ramWe, 0);
    cpuReq = 1'b0;
    tick();
    checkVal("w3_ack", cpuAck, 0);

    // CPU read back
    cpuReq = 1'b1;
    cpuWe = 1'b0;
    tick();
    checkVal("r1_ramWe", ramWe, 0);
    checkVal("r1_ramAddr", ramAddr, 14'h3FFF);
    checkVal("r1_ack", cpuAck, 0);
    tick();
    checkVal("r2_ack", cpuAck, 0);
    tick();
    checkVal("r3_ack", cpuAck, 1);
    checkVal("r3_rdata", cpuRData, 8'hA5);
    cpuReq = 1'b0;
    tick();
    checkVal("r4_ack", cpuAck, 0);

    // simultaneous requests: display first, CPU on the following idle edge
    dispReq = 1'b1;
    dispAddr = 14'h0200;
    cpuReq = 1'b1;
    cpuWe = 1'b0;
    cpuAddr = 14'h0123;
    tick();
    checkVal("s1_gnt", dispGnt, 1);
    checkVal("s1_ramAddr", ramAddr, 14'h0200);
    dispReq = 1'b0;
    tick();
    checkVal("s2_gnt", dispGnt, 0);
    checkVal("s2_ramAddr", ramAddr, 14'h0123);
    tick();
    checkVal("s3_valid", dispValid, 1);
    checkVal("s3_data", dispData, 8'h77);
    checkVal("s3_ack", cpuAck, 0);
    tick();
    checkVal("s4_ack", cpuAck, 1);
    checkVal("s4_rdata", cpuRData, 8'h5A);
    cpuReq = 1'b0;
    tick();

    // starvation with STARVE_MAX=4: CPU forced through at the fifth edge
    dispReq = 1'b1;
    dispAddr = 14'h0105;
    cpuReq = 1'b1;
    cpuWe = 1'b0;
    cpuAddr = 14'h0123;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checkVal("st_gnt", dispGnt, (c == 5) ? 0 : 1);
      checkVal("st_ack", cpuAck, (c == 7) ? 1 : 0);
      checkVal("st_valid", dispValid, (c >= 3 && c != 7) ? 1 : 0);
      if (c == 5) checkVal("st_ramAddr", ramAddr, 14'h0123);
      if (c == 7) begin
        checkVal("st_rdata", cpuRData, 8'h5A);
        cpuReq = 1'b0;
      end
    end
    dispReq = 1'b0;
    tick();
    tick();
    tick();
    checkVal("st_drain_valid", dispValid, 0);

    // asynchronous reset during a write issue cycle
    cpuReq = 1'b1;
    cpuWe = 1'b1;
    cpuAddr = 14'h0042;
    cpuWData = 8'h3C;
    tick();
    checkVal("rw_ramWe_issue", ramWe, 1);
    #2;
    reset = 1'b0;
    #1;
    checkVal("rw_ramWe_async", ramWe, 0);
    checkVal("rw_ack_async", cpuAck, 0);
    tick();
    checkVal("rw_ack_hold1", cpuAck, 0);
    tick();
    checkVal("rw_ack_hold2", cpuAck, 0);
    checkVal("rw_ramWe_hold", ramWe, 0);
    reset = 1'b1;
    tick();
    checkVal("rw_restart_ramWe", ramWe, 1);
    checkVal("rw_restart_ramAddr", ramAddr, 14'h0042);
    checkVal("rw_restart_ack1", cpuAck, 0);
    tick();
    checkVal("rw_restart_ack2", cpuAck, 1);
    checkVal("rw_restart_ramWe2", ramWe, 0);
    cpuReq = 1'b0;
    tick();
    checkVal("rw_restart_ack3", cpuAck, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
